tmr_regfile: RTL

Triple-modular-redundant replacement for the 32x32 three-port register file. It feeds operands directly to the redundant ALU in the execute stage. Three copies are held, each read returns a bitwise 2-of-3 majority, and writes go to all copies. A background scrubber walks registers 1..31 one per cycle and rewrites the voted value into all copies, clearing latent upsets. A verification-only injection port flips bits in a single copy.

---
 rtl/tmr_regfile.sv | 101 ++++++++++
 1 files changed

// File: rtl/tmr_regfile.sv
// Triple-modular-redundant 32x32 register file: 2-of-3 voted reads, background
// scrubber that rewrites voted values, and a single-copy fault injection port.
module tmr_regfile #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we3,
    input  logic [4:0]       ra1,
    input  logic [4:0]       ra2,
    input  logic [4:0]       wa3,
    input  logic [31:0]      wd3,
    output logic [31:0]      rd1,
    output logic [31:0]      rd2,
    output logic             rd1_err,
    output logic             rd2_err,
    input  logic             scrub_en,
    output logic             scrub_done,
    output logic [CNT_W-1:0] fault_cnt,
    output logic             multi_fault,
    input  logic             inj_en,
    input  logic [1:0]       inj_copy,
    input  logic [4:0]       inj_addr,
    input  logic [31:0]      inj_mask
);

    logic [31:0] mem [0:2][0:31];
    logic [4:0]  scrub_ptr;

    function automatic logic [31:0] vote(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic [31:0] v1, v2;
    assign v1 = vote(mem[0][ra1], mem[1][ra1], mem[2][ra1]);
    assign v2 = vote(mem[0][ra2], mem[1][ra2], mem[2][ra2]);

    always_comb begin
        rd1     = '0;
        rd1_err = 1'b0;
        rd2     = '0;
        rd2_err = 1'b0;
        if (ra1 != 5'd0) begin
            rd1     = v1;
            rd1_err = (mem[0][ra1] != v1) || (mem[1][ra1] != v1) || (mem[2][ra1] != v1);
        end
        if (ra2 != 5'd0) begin
            rd2     = v2;
            rd2_err = (mem[0][ra2] != v2) || (mem[1][ra2] != v2) || (mem[2][ra2] != v2);
        end
    end

    logic [31:0] s_v;
    logic [2:0]  s_diff;
    logic        s_blocked, s_fix, s_multi;

    assign s_v       = vote(mem[0][scrub_ptr], mem[1][scrub_ptr], mem[2][scrub_ptr]);
    assign s_diff    = {mem[2][scrub_ptr] != s_v, mem[1][scrub_ptr] != s_v,
                        mem[0][scrub_ptr] != s_v};
    // A same-cycle write or valid injection to the scrubbed address owns it.
    assign s_blocked = (we3 && (wa3 == scrub_ptr)) ||
                       (inj_en && (inj_copy != 2'd3) && (inj_addr == scrub_ptr));
    assign s_fix     = scrub_en && (s_diff != 3'b000) && !s_blocked;
    assign s_multi   = (s_diff[0] & s_diff[1]) | (s_diff[0] & s_diff[2]) |
                       (s_diff[1] & s_diff[2]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < 3; k++)
                for (int unsigned r = 0; r < 32; r++)
                    mem[k][r] <= '0;
            scrub_ptr   <= 5'd1;
            scrub_done  <= 1'b0;
            fault_cnt   <= '0;
            multi_fault <= 1'b0;
        end else begin
            scrub_done <= scrub_en && (scrub_ptr == 5'd31);
            if (scrub_en)
                scrub_ptr <= (scrub_ptr == 5'd31) ? 5'd1 : scrub_ptr + 5'd1;
            if (s_fix) begin
                for (int unsigned k = 0; k < 3; k++)
                    mem[k][scrub_ptr] <= s_v;
                if (fault_cnt != '1)
                    fault_cnt <= fault_cnt + 1'b1;
                if (s_multi)
                    multi_fault <= 1'b1;
            end
            if (we3 && (wa3 != 5'd0))
                for (int unsigned k = 0; k < 3; k++)
                    mem[k][wa3] <= wd3;
            // Injection is ordered after the write so its copy ends up as wd3 ^ mask.
            if (inj_en && (inj_addr != 5'd0))
                for (int unsigned k = 0; k < 3; k++)
                    if (inj_copy == 2'(k))
                        mem[k][inj_addr] <= ((we3 && (wa3 == inj_addr)) ? wd3
                                             : mem[k][inj_addr]) ^ inj_mask;
        end
    end

endmodule
